// File: rtl/argmax_classifier.sv
// argmax_classifier: captures NB_CLASSES signed scores and scans them with one compare per clock.
// Optional feature ARGMAX_MARGIN_EN adds second-best tracking that drives margin_out.
module argmax_classifier #(
    parameter int NB_CLASSES = 10,
    parameter int WIDTH      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] in_data [0:NB_CLASSES-1],
    input  logic                    in_valid,
    output logic [IDX_W-1:0]        class_out,
    output logic signed [WIDTH-1:0] max_out,
    output logic [WIDTH:0]          margin_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NB_CLASSES - 1);

    state_t                  state;
    state_t                  state_next;
    logic                    in_valid_q;
    logic                    start;
    logic                    last;
    logic signed [WIDTH-1:0] score_buf [0:NB_CLASSES-1];
    logic signed [WIDTH-1:0] cand;
    logic signed [WIDTH-1:0] best_val;
    logic signed [WIDTH-1:0] best_val_next;
    logic [IDX_W-1:0]        best_idx;
    logic [IDX_W-1:0]        best_idx_next;
    logic [IDX_W-1:0]        ptr;

    // Only a rising edge of the layer's done level starts a classification.
    assign start = enable && in_valid && !in_valid_q;
    assign cand  = score_buf[ptr];
    assign last  = (ptr == LAST_PTR);

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_next    = state;
        best_val_next = best_val;
        best_idx_next = best_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // Strict compare: ties keep the lower index already held.
                if (cand > best_val) begin
                    best_val_next = cand;
                    best_idx_next = ptr;
                end
                if (enable && last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_q <= 1'b0;
            ptr        <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            class_out  <= '0;
            max_out    <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            // NOTE: the score buffer is cleared on reset because its zero state is defined behaviour.
            for (int i = 0; i < NB_CLASSES; i++) begin
                score_buf[i] <= '0;
            end
        end else if (enable) begin
            in_valid_q <= in_valid;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    score_buf <= in_data;
                    best_val  <= in_data[0];
                    best_idx  <= '0;
                    ptr       <= IDX_W'(1);
                    busy      <= 1'b1;
                end
            end else begin
                best_val <= best_val_next;
                best_idx <= best_idx_next;
                ptr      <= ptr + 1'b1;
                overrun  <= start;
                if (last) begin
                    class_out <= best_idx_next;
                    max_out   <= best_val_next;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    ptr       <= '0;
                end
            end
        end
    end

`ifdef ARGMAX_MARGIN_EN
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] second_val;
    logic signed [WIDTH-1:0] second_val_next;
    logic [WIDTH:0]          margin_next;

    always_comb begin
        second_val_next = second_val;
        if (cand > best_val) begin
            second_val_next = best_val;
        end else if ((cand > second_val) || (cand == best_val)) begin
            second_val_next = cand;
        end
        // Sign-extend both operands by one bit; best >= second, so the result is non-negative.
        margin_next = {best_val_next[WIDTH-1], best_val_next}
                    - {second_val_next[WIDTH-1], second_val_next};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            second_val <= '0;
            margin_out <= '0;
        end else if (enable) begin
            if (state == IDLE) begin
                if (start) begin
                    second_val <= MOST_NEG;
                end
            end else begin
                second_val <= second_val_next;
                if (last) begin
                    margin_out <= margin_next;
                end
            end
        end
    end
`else
    assign margin_out = '0;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed table, corner sequences, random vs. model.
`timescale 1ns/1ps
module tb_argmax_classifier;

    localparam int NB = 10;
    localparam int W  = 16;
    localparam int IW = 4;
`ifdef ARGMAX_MARGIN_EN
    localparam bit MARGIN_EN = 1'b1;
`else
    localparam bit MARGIN_EN = 1'b0;
`endif

    typedef logic signed [W-1:0] score_t;
    typedef int score_arr_t [0:NB-1];
    typedef struct {
        score_arr_t scores;
        int         exp_idx;
        int         exp_max;
        int         exp_margin;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          enable;
    score_t        in_data [0:NB-1];
    logic          in_valid;
    logic [IW-1:0] class_out;
    score_t        max_out;
    logic [W:0]    margin_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    argmax_classifier #(
        .NB_CLASSES(NB),
        .WIDTH     (W),
        .IDX_W     (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .class_out (class_out),
        .max_out   (max_out),
        .margin_out(margin_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index of the largest score; margin is largest minus the
    // largest of the remaining scores (a duplicate maximum gives zero).
    task automatic model(input score_arr_t s, output int idx, output int mx, output int mg);
        int second;
        idx = 0;
        for (int i = 1; i < NB; i++) begin
            if (s[i] > s[idx]) idx = i;
        end
        mx     = s[idx];
        second = -2147483647;
        for (int i = 0; i < NB; i++) begin
            if (i != idx && s[i] > second) second = s[i];
        end
        mg = MARGIN_EN ? (mx - second) : 0;
    endtask

    task automatic drive_scores(input score_arr_t s);
        for (int i = 0; i < NB; i++) begin
            in_data[i] = score_t'(s[i]);
        end
    endtask

    // Presents scores with a rising in_valid; returns just after the capture edge.
    task automatic apply_start(input score_arr_t s);
        drive_scores(s);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Steps until out_valid, bounded; n counts edges stepped.
    task automatic wait_result(input string name, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({name, "_out_valid_seen"}, 32'(out_valid), 1);
    endtask

    task automatic check_result(input string name, input int idx, input int mx, input int mg);
        check({name, "_class"},  32'(class_out),  idx);
        check({name, "_max"},    32'(max_out),    mx);
        check({name, "_margin"}, 32'(margin_out), mg);
    endtask

    vec_t       vecs [0:6];
    score_arr_t rs;
    int         n;
    int         n2;
    int         e_idx;
    int         e_max;
    int         e_mg;
    bit         seen;
    logic signed [15:0] r16;

    initial begin
        vecs[0].scores = '{0, 5, 3, 90, 2, 0, 0, 7, 1, 4};
        vecs[0].exp_idx = 3;  vecs[0].exp_max = 90;     vecs[0].exp_margin = 83;
        vecs[1].scores = '{50, 0, 0, 0, 0, 0, 0, 0, 0, 50};
        vecs[1].exp_idx = 0;  vecs[1].exp_max = 50;     vecs[1].exp_margin = 0;
        vecs[2].scores = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].exp_idx = 0;  vecs[2].exp_max = 0;      vecs[2].exp_margin = 0;
        vecs[3].scores = '{-5, -3, -3, -100, -7, -8, -9, -10, -11, -12};
        vecs[3].exp_idx = 1;  vecs[3].exp_max = -3;     vecs[3].exp_margin = 0;
        vecs[4].scores = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767};
        vecs[4].exp_idx = 9;  vecs[4].exp_max = 32767;  vecs[4].exp_margin = 65535;
        vecs[5].scores = '{32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        vecs[5].exp_idx = 0;  vecs[5].exp_max = 32767;  vecs[5].exp_margin = 65535;
        vecs[6].scores = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        vecs[6].exp_idx = 9;  vecs[6].exp_max = 10;     vecs[6].exp_margin = 1;

        reset    = 1'b1;
        enable   = 1'b1;
        in_valid = 1'b0;
        drive_scores('{default: 0});
        step();
        step();
        check("reset_class",     32'(class_out),  0);
        check("reset_max",       32'(max_out),    0);
        check("reset_margin",    32'(margin_out), 0);
        check("reset_out_valid", 32'(out_valid),  0);
        check("reset_busy",      32'(busy),       0);
        check("reset_overrun",   32'(overrun),    0);
        reset = 1'b0;
        step();

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            apply_start(vecs[v].scores);
            check($sformatf("vec%0d_busy", v), 32'(busy), 1);
            wait_result($sformatf("vec%0d", v), n);
            check($sformatf("vec%0d_latency", v), n, NB - 1);
            check_result($sformatf("vec%0d", v), vecs[v].exp_idx, vecs[v].exp_max,
                         MARGIN_EN ? vecs[v].exp_margin : 0);
            check($sformatf("vec%0d_busy_done", v), 32'(busy), 0);
            step();
            check($sformatf("vec%0d_pulse_end", v), 32'(out_valid), 0);
            check($sformatf("vec%0d_hold_class", v), 32'(class_out), vecs[v].exp_idx);
            step();
        end

        // Overrun 4 cycles into a scan, then back-to-back start in the out_valid cycle.
        apply_start(vecs[0].scores);
        step(); step(); step();
        drive_scores(vecs[6].scores);
        in_valid = 1'b1;
        step();
        check("ovr_pulse", 32'(overrun), 1);
        in_valid = 1'b0;
        step();
        check("ovr_pulse_end", 32'(overrun), 0);
        wait_result("ovr", n);
        check("ovr_latency", n + 5, NB - 1);
        check_result("ovr_first", 3, 90, MARGIN_EN ? 83 : 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_no_overrun", 32'(overrun), 0);
        wait_result("b2b", n);
        check("b2b_latency", n, NB - 1);
        check_result("b2b", 9, 10, MARGIN_EN ? 1 : 0);
        step();

        // Enable held low for 3 cycles mid-scan.
        apply_start(vecs[3].scores);
        step(); step(); step();
        enable = 1'b0;
        step(); step(); step();
        check("stall_busy", 32'(busy), 1);
        check("stall_no_valid", 32'(out_valid), 0);
        enable = 1'b1;
        wait_result("stall", n);
        check("stall_latency", n + 6, NB + 2);
        check_result("stall", 1, -3, 0);
        step();

        // Reset mid-scan aborts without a result.
        apply_start(vecs[0].scores);
        step(); step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_class",   32'(class_out),  0);
        check("rst_mid_max",     32'(max_out),    0);
        check("rst_mid_margin",  32'(margin_out), 0);
        check("rst_mid_busy",    32'(busy),       0);
        check("rst_mid_valid",   32'(out_valid),  0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("rst_mid_no_result", 32'(seen), 0);
        apply_start(vecs[6].scores);
        wait_result("rst_after", n);
        check("rst_after_latency", n, NB - 1);
        check_result("rst_after", 9, 10, MARGIN_EN ? 1 : 0);
        step();

        // Random scores against the reference model; narrow ranges provoke ties.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NB; i++) begin
                if (t % 2 == 0) begin
                    rs[i] = int'($urandom_range(0, 16)) - 8;
                end else begin
                    r16   = 16'($urandom);
                    rs[i] = int'(r16);
                end
            end
            model(rs, e_idx, e_max, e_mg);
            apply_start(rs);
            drive_scores('{default: 0});
            wait_result($sformatf("rand%0d", t), n2);
            check($sformatf("rand%0d_latency", t), n2, NB - 1);
            check_result($sformatf("rand%0d", t), e_idx, e_max, e_mg);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Final classification stage of the MNIST inference pipeline, directly downstream of the output dense layer. It captures the 10 ReLU-activated class scores when the layer signals done, then scans them serially with one comparison per clock. It reports the winning class index, its score and a one-cycle valid pulse. The block is time-multiplexed, with a single comparator, so it adds no per-class logic.

## Interface
- `NB_CLASSES`, default 10: number of class scores; must be ≥ 2.
- `WIDTH`, default 16: signed score width.
- `IDX_W`, default 4: index width; must satisfy 2^IDX_W ≥ NB_CLASSES.

Ports:
- `clk`, input, 1: single clock; every register updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: global advance enable. While low, all state and outputs hold.
- `in_data`, input, signed [WIDTH-1:0] [0:NB_CLASSES-1]: class scores from the output dense layer.
- `in_valid`, input, 1: the output layer's `layer_done` level. A rising edge starts a classification.
- `class_out`, output, [IDX_W-1:0]: index of the maximum score.
- `max_out`, output, signed [WIDTH-1:0]: the maximum score.
- `margin_out`, output, [WIDTH:0]: best score minus second-best score (see Configuration).
- `out_valid`, output, 1: one-cycle pulse when the results update.
- `busy`, output, 1: high while a scan is in progress.
- `overrun`, output, 1: one-cycle pulse when a start request is dropped because a scan is in progress.

## Operation
- A register `in_valid_q` samples `in_valid` every enabled cycle. Start condition: `enable && in_valid && !in_valid_q`.
- The FSM has two states, IDLE and SCAN.
- IDLE, on start:
  - Copy all of `in_data` into the internal buffer `buf`.
  - `best_val <= in_data[0]`, `best_idx <= 0`, `ptr <= 1`.
  - Go to SCAN and raise `busy`.
- SCAN, each enabled cycle:
  - If `buf[ptr] > best_val` (strict signed compare), then `best_val <= buf[ptr]` and `best_idx <= ptr`.
  - Increment `ptr`.
  - When `ptr == NB_CLASSES-1`, the compare on that edge uses the updated-best rule above. On the same edge, load `class_out` and `max_out` with the post-compare best, set `out_valid <= 1`, drop `busy`, and return to IDLE.
- Ties always keep the lowest index.
- Scores are never modified; there is no saturation or widening, except for `margin_out`.
- `class_out`, `max_out` and `margin_out` hold their last value until the next `out_valid`.
- Start while in SCAN: nothing is captured, the scan is unaffected, and `overrun` pulses for one cycle.
- `enable` low during SCAN: the block stalls. `ptr`, `buf` and the best registers freeze, and `in_valid_q` does not update. The scan resumes when `enable` returns.
- `in_data` may change after the capture edge without affecting the result.

## Timing
- Capture edge E. `out_valid` is high for exactly the cycle after edge E+NB_CLASSES-1 (E+9 by default), assuming no stalls. Each disabled cycle adds one cycle of latency.
- `busy` is high from edge E through edge E+NB_CLASSES-1. It falls on the edge where `out_valid` rises.
- Back-to-back operation: a rising edge of `in_valid` in the same cycle that `out_valid` is high is accepted, because the state is already IDLE.
- Reset values: `class_out` = 0, `max_out` = 0, `margin_out` = 0, `out_valid` = 0, `busy` = 0, `overrun` = 0, state = IDLE, `ptr` = 0, `in_valid_q` = 0, `buf` = 0.
- Because `in_valid_q` resets to 0, an `in_valid` held high through reset triggers a capture on the first enabled edge after reset.
- Reset asserted mid-scan aborts the scan immediately, with no `out_valid`.

## Configuration
- `ARGMAX_MARGIN_EN` defined:
  - A second-best register is added. It initialises to the most negative WIDTH-bit value at capture.
  - When a new score is greater than the best, the old best moves to second-best. Otherwise, if the new score is greater than second-best, it becomes second-best. A score equal to the best becomes second-best.
  - `margin_out <= best - second`, computed in WIDTH+1 bits and always non-negative. It updates with `out_valid`.
- `ARGMAX_MARGIN_EN` undefined: no second-best logic exists and `margin_out` is tied to 0.

## Test plan
- Scores {0,5,3,90,2,0,0,7,1,4} with a rising edge on `in_valid` → 10 cycles after the capture edge, `out_valid` pulses with `class_out`=3 and `max_out`=90. `margin_out`=83 with the macro, 0 without.
- Scores with the maximum at both index 0 and index 9 ({50,0,…,0,50}) → `class_out`=0. `margin_out`=0 with the macro.
- All-zero scores → `class_out`=0, `max_out`=0, and `out_valid` still pulses.
- A second `in_valid` rising edge 4 cycles into a scan → `overrun` pulses for 1 cycle and the first result is unchanged. Then a rising edge during the `out_valid` cycle → the next scan is accepted and its result appears 10 cycles later.
- `enable` held low for 3 cycles mid-scan → `out_valid` arrives 13 cycles after capture with the correct result.
- Reset pulsed mid-scan → all outputs are 0, there is no `out_valid`, and a subsequent start works normally.
